rv_dmem_bridge: RTL and testbench

RV_DMEM_BRIDGE -- requirements
Module: rv_dmem_bridge

---
 rtl/rv_dmem_bridge_pkg.sv | 15 +
 rtl/rv_dmem_bridge_timer.sv | 29 ++
 rtl/rv_dmem_bridge.sv | 126 ++++++++++++
 tb/tb_rv_dmem_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_dmem_bridge_pkg.sv
// Shared definitions for the CPU data-memory to bus bridge:
// FSM state encoding, timer width and the default error load value.
package rv_dmem_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUS_RD = 2'd1,
      ST_BUS_WR = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int          TIMER_W          = 8;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/rv_dmem_bridge_timer.sv
// Bus watchdog: counts cycles while enabled, flags expiry on the LIMIT-th cycle.
module rv_bus_timer
   import rv_dmem_bridge_pkg::*;
#(
   parameter int LIMIT = 63
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TIMER_W-1:0] cnt_q;

   // cnt_q holds (cycles already spent enabled), so expiry fires in cycle LIMIT.
   assign expired = enable && (cnt_q == TIMER_W'(LIMIT - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/rv_dmem_bridge.sv
// Bridges single CPU load/store requests onto a req/ack/err bus with a
// watchdog timeout; every request ends in exactly one done pulse.
module rv_dmem_bridge
   import rv_dmem_bridge_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 63,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_load_i,
   input  logic        dm_store_i,
   output logic [31:0] dm_data_l_o,
   output logic        dm_ready_o,
   output logic        dm_load_done_o,
   output logic        dm_store_done_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_data_o,
   output logic [3:0]  bus_sel_o,
   output logic        bus_we_o,
   output logic        bus_req_o,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   output logic        err_o,
   output logic [31:0] err_addr_o,
   output logic [1:0]  dbg_state_o
);

   // Handshake: the CPU side offers dm_load_i/dm_store_i and a request is taken
   // on any edge where dm_ready_o=1. The bus side holds bus_req_o and all bus_*
   // fields constant until an edge with bus_ack_i or bus_err_i, or a timeout.

   state_e state_q, state_n;
   logic   timer_clr, timer_en, timer_exp;
   logic   bus_end, bus_fail;

   rv_bus_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clear   (timer_clr),
      .enable  (timer_en),
      .expired (timer_exp)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_n;
   end

   always_comb begin
      state_n    = state_q;
      dm_ready_o = 1'b0;
      timer_clr  = 1'b0;
      timer_en   = 1'b0;
      bus_end    = 1'b0;
      bus_fail   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            dm_ready_o = 1'b1;
            timer_clr  = 1'b1;
            if (dm_load_i)       state_n = ST_BUS_RD;
            else if (dm_store_i) state_n = ST_BUS_WR;
         end
         ST_BUS_RD, ST_BUS_WR: begin
            timer_en = 1'b1;
            // Error and timeout outrank a simultaneous ack.
            bus_fail = bus_err_i || timer_exp;
            bus_end  = bus_fail || bus_ack_i;
            if (bus_end) state_n = ST_DONE;
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   assign dbg_state_o = state_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dm_data_l_o     <= '0;
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         bus_addr_o      <= '0;
         bus_data_o      <= '0;
         bus_sel_o       <= '0;
         bus_we_o        <= 1'b0;
         bus_req_o       <= 1'b0;
         err_o           <= 1'b0;
         err_addr_o      <= '0;
      end else begin
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         err_o           <= 1'b0;
         if (state_q == ST_IDLE && (dm_load_i || dm_store_i)) begin
            bus_addr_o <= dm_addr_i;
            bus_sel_o  <= dm_data_select_i;
            bus_we_o   <= !dm_load_i;
            bus_req_o  <= 1'b1;
            if (!dm_load_i) bus_data_o <= dm_data_s_i;
            // Conflicting request: the load wins and the dropped store is flagged.
            if (dm_load_i && dm_store_i) begin
               err_o      <= 1'b1;
               err_addr_o <= dm_addr_i;
            end
         end
         if (bus_end) begin
            bus_req_o <= 1'b0;
            if (state_q == ST_BUS_RD) begin
               dm_load_done_o <= 1'b1;
               dm_data_l_o    <= bus_fail ? ERR_DATA : bus_data_i;
            end else begin
               dm_store_done_o <= 1'b1;
            end
            if (bus_fail) begin
               err_o      <= 1'b1;
               err_addr_o <= bus_addr_o;
            end
         end
      end
   end

endmodule

// File: tb/tb_rv_dmem_bridge.sv
// Self-checking bench for rv_dmem_bridge: directed vector table, randomized
// transactions against a transaction-level model, and a mid-store reset.
module tb_rv_dmem_bridge;

   localparam int          T     = 63;
   localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

   logic        clk, rst_n;
   logic [31:0] dm_addr, dm_data_s, dm_data_l;
   logic [3:0]  dm_sel;
   logic        dm_load, dm_store, dm_ready, ld_done, st_done;
   logic [31:0] bus_addr, bus_wdata, bus_rdata, err_addr;
   logic [3:0]  bus_sel;
   logic        bus_we, bus_req, bus_ack, bus_err, err_o;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          req_cycles;
      int          done_cycle;
      int          ld_dones;
      int          st_dones;
      int          errs;
      int          unstable;
      int          timed_out;
      logic [31:0] data;
      logic [31:0] eaddr;
   } obs_t;

   typedef struct {
      bit          ld;
      bit          st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          wait_c;
      bit          ack;
      bit          err;
      logic [31:0] rdata;
      int          e_req;
      int          e_done;
      int          e_ld;
      int          e_st;
      int          e_errs;
      logic [31:0] e_data;
      logic [31:0] e_eaddr;
   } vec_t;

   vec_t vt[6];

   rv_dmem_bridge #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR_D)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .dm_addr_i        (dm_addr),
      .dm_data_s_i      (dm_data_s),
      .dm_data_select_i (dm_sel),
      .dm_load_i        (dm_load),
      .dm_store_i       (dm_store),
      .dm_data_l_o      (dm_data_l),
      .dm_ready_o       (dm_ready),
      .dm_load_done_o   (ld_done),
      .dm_store_done_o  (st_done),
      .bus_addr_o       (bus_addr),
      .bus_data_o       (bus_wdata),
      .bus_sel_o        (bus_sel),
      .bus_we_o         (bus_we),
      .bus_req_o        (bus_req),
      .bus_data_i       (bus_rdata),
      .bus_ack_i        (bus_ack),
      .bus_err_i        (bus_err),
      .err_o            (err_o),
      .err_addr_o       (err_addr),
      .dbg_state_o      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Driver: issues one request (caller is #1 after an edge with dm_ready=1),
   // plays the bus slave and observes until the bridge is ready again.
   task automatic run_txn(input bit ld, input bit st, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input int wait_c, input bit ack, input bit err,
                          input logic [31:0] rdata, output obs_t o);
      int  c;
      bit  we_exp;
      o = '{default: 0};
      o.timed_out = 1;
      we_exp = !ld;
      dm_load = ld; dm_store = st; dm_addr = addr; dm_data_s = wdata; dm_sel = sel;
      c = 0;
      while (c < 300) begin
         @(posedge clk); #1; c++;
         dm_load = 1'b0; dm_store = 1'b0;
         dm_addr = $urandom; dm_data_s = $urandom; dm_sel = 4'($urandom_range(0, 15));
         bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
         if (bus_req) begin
            o.req_cycles++;
            if (bus_addr !== addr || bus_sel !== sel || bus_we !== we_exp ||
                (we_exp && bus_wdata !== wdata)) o.unstable++;
         end
         if (ld_done) begin o.ld_dones++; o.done_cycle = c; end
         if (st_done) begin o.st_dones++; o.done_cycle = c; end
         if (err_o) o.errs++;
         if (dm_ready) begin o.timed_out = 0; break; end
         if (c == wait_c + 1) begin
            bus_ack = ack; bus_err = err; bus_rdata = rdata;
         end
      end
      o.data  = dm_data_l;
      o.eaddr = err_addr;
   endtask

   // scoreboard comparison of one observed transaction against expectations
   task automatic check_obs(input string tag, input obs_t o, input int e_req,
                            input int e_done, input int e_ld, input int e_st,
                            input int e_errs, input logic [31:0] e_data,
                            input logic [31:0] e_eaddr);
      chk({tag, " timeout"},    o.timed_out,  0);
      chk({tag, " req_cycles"}, o.req_cycles, e_req);
      chk({tag, " done_cycle"}, o.done_cycle, e_done);
      chk({tag, " load_done"},  o.ld_dones,   e_ld);
      chk({tag, " store_done"}, o.st_dones,   e_st);
      chk({tag, " err_pulses"}, o.errs,       e_errs);
      chk({tag, " bus_stable"}, o.unstable,   0);
      chk({tag, " load_data"},  o.data,       e_data);
      chk({tag, " err_addr"},   o.eaddr,      e_eaddr);
   endtask

   initial begin
      obs_t        o;
      logic [31:0] m_data, m_eaddr;
      bit          ld, st, ack, err, resp, fail;
      int          wait_c, n_req, seen;
      logic [31:0] addr, wdata, rdata;
      logic [3:0]  sel;

      vt[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hCAFEF00D,
                1, 2, 1, 0, 0, 32'hCAFEF00D, 32'h0};
      vt[1] = '{1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011, 5, 1'b1, 1'b0, 32'h0,
                6, 7, 0, 1, 0, 32'hCAFEF00D, 32'h0};
      vt[2] = '{1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0,
                T, T + 1, 1, 0, 1, ERR_D, 32'h300};
      vt[3] = '{1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 2, 1'b1, 1'b1, 32'h11111111,
                3, 4, 1, 0, 1, ERR_D, 32'h400};
      vt[4] = '{1'b1, 1'b1, 32'h500, 32'h99999999, 4'hF, 1, 1'b1, 1'b0, 32'hA5A55A5A,
                2, 3, 1, 0, 1, 32'hA5A55A5A, 32'h500};
      vt[5] = '{1'b0, 1'b1, 32'h600, 32'h77, 4'h1, 0, 1'b0, 1'b1, 32'h0,
                1, 2, 0, 1, 1, 32'hA5A55A5A, 32'h600};

      rst_n = 1'b0;
      dm_addr = '0; dm_data_s = '0; dm_sel = '0; dm_load = 1'b0; dm_store = 1'b0;
      bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready",    dm_ready,  1);
      chk("rst bus_req",  bus_req,   0);
      chk("rst data_l",   dm_data_l, 0);
      chk("rst err_addr", err_addr,  0);
      chk("rst err",      err_o,     0);
      chk("rst dones",    {ld_done, st_done}, 0);
      chk("rst bus_addr", bus_addr,  0);
      chk("rst state",    dbg_state, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed vectors
      for (int i = 0; i < 6; i++) begin
         run_txn(vt[i].ld, vt[i].st, vt[i].addr, vt[i].wdata, vt[i].sel,
                 vt[i].wait_c, vt[i].ack, vt[i].err, vt[i].rdata, o);
         check_obs($sformatf("vec%0d", i), o, vt[i].e_req, vt[i].e_done,
                   vt[i].e_ld, vt[i].e_st, vt[i].e_errs, vt[i].e_data, vt[i].e_eaddr);
      end

      // randomized transactions against a transaction-level model
      m_data  = vt[5].e_data;
      m_eaddr = vt[5].e_eaddr;
      for (int i = 0; i < 40; i++) begin
         ld     = 1'($urandom_range(0, 1));
         st     = ld ? ($urandom_range(0, 3) == 0) : 1'b1;
         resp   = ($urandom_range(0, 9) != 0);
         ack    = resp && ($urandom_range(0, 3) != 0);
         err    = resp && (!ack || $urandom_range(0, 4) == 0);
         wait_c = $urandom_range(0, 6);
         addr   = $urandom; wdata = $urandom; rdata = $urandom;
         sel    = 4'($urandom_range(0, 15));
         run_txn(ld, st, addr, wdata, sel, wait_c, ack, err, rdata, o);
         resp  = (ack || err) && (wait_c + 1 <= T);
         fail  = resp ? err : 1'b1;
         n_req = resp ? wait_c + 1 : T;
         if (ld) m_data = fail ? ERR_D : rdata;
         if (fail || (ld && st)) m_eaddr = addr;
         check_obs($sformatf("rnd%0d", i), o, n_req, n_req + 1, ld ? 1 : 0,
                   ld ? 0 : 1, int'(fail) + int'(ld && st), m_data, m_eaddr);
      end

      // reset three cycles into a store
      dm_store = 1'b1; dm_addr = 32'h700; dm_data_s = 32'h0BAD_0BAD; dm_sel = 4'hF;
      repeat (3) begin
         @(posedge clk); #1;
         dm_store = 1'b0;
      end
      chk("mid-store bus_req", bus_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst bus_req", bus_req,   0);
      chk("async rst ready",   dm_ready,  1);
      chk("async rst state",   dbg_state, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      bus_ack = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         seen += int'(ld_done) + int'(st_done) + int'(bus_req) + int'(!dm_ready);
      end
      bus_ack = 1'b0;
      chk("post-rst late ack ignored", seen,      0);
      chk("post-rst data_l",           dm_data_l, 0);
      chk("post-rst err_addr",         err_addr,  0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
